// File: rtl/store_buffer_if.sv
// store_buffer_if: core load/store port and memory port of the store buffer.
interface store_buffer_if;
    logic        core_we;
    logic        core_re;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_be;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport master (
        output core_we, core_re, core_addr, core_wdata, core_be, mem_ack, mem_rdata,
        input  core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
    modport slave (
        input  core_we, core_re, core_addr, core_wdata, core_be, mem_ack, mem_rdata,
        output core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry store FIFO draining to memory; define STORE_FWD_EN for load forwarding.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           n_rst,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [29:0]   ent_addr_q [DEPTH];
    logic [29:0]   ent_addr_d [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [3:0]    ent_be_q [DEPTH];
    logic [3:0]    ent_be_d [DEPTH];
    logic          full, empty, ack, enq, deq, load_done, fwd, eligible, unused_addr_lsb;
    logic [31:0]   fwd_data;
    assign unused_addr_lsb = ^bus.core_addr[1:0];
    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign ack       = bus.mem_ack & n_rst;
    assign enq       = bus.core_we & ~full;
    assign deq       = state_q == WR_REQ && ack;
    assign load_done = state_q == RD_REQ && ack;
`ifdef STORE_FWD_EN
    logic          match_any;
    logic [3:0]    lane_hit;
    logic [PW-1:0] idx;
    // Scanning oldest to youngest lets younger stores overwrite lanes.
    always_comb begin
        match_any = 1'b0;
        lane_hit  = '0;
        fwd_data  = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q && ent_addr_q[idx] == bus.core_addr[31:2]) begin
                match_any = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    if (bus.core_be[l] && ent_be_q[idx][l]) begin
                        lane_hit[l]        = 1'b1;
                        fwd_data[8*l +: 8] = ent_data_q[idx][8*l +: 8];
                    end
                end
            end
        end
    end
    assign fwd      = bus.core_re & match_any & (lane_hit == bus.core_be);
    assign eligible = ~match_any;
`else
    assign fwd      = 1'b0;
    assign fwd_data = '0;
    assign eligible = empty;
`endif
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(enq);
        rd_ptr_d   = rd_ptr_q + PW'(deq);
        count_d    = count_q + CW'(enq) - CW'(deq);
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_be_d   = ent_be_q;
        if (enq) begin
            ent_addr_d[wr_ptr_q] = bus.core_addr[31:2];
            ent_data_d[wr_ptr_q] = bus.core_wdata;
            ent_be_d[wr_ptr_q]   = bus.core_be;
        end
        state_d = state_q == IDLE ? (bus.core_re && !fwd && eligible ? RD_REQ : !empty ? WR_REQ : IDLE)
                : ack ? IDLE : state_q;
    end
    assign bus.mem_req    = state_q != IDLE;
    assign bus.mem_we     = state_q == WR_REQ;
    assign bus.mem_addr   = state_q == WR_REQ ? {ent_addr_q[rd_ptr_q], 2'b00}
                          : state_q == RD_REQ ? {bus.core_addr[31:2], 2'b00} : '0;
    assign bus.mem_wdata  = state_q == WR_REQ ? ent_data_q[rd_ptr_q] : '0;
    assign bus.mem_be     = state_q == WR_REQ ? ent_be_q[rd_ptr_q] : state_q == RD_REQ ? bus.core_be : '0;
    assign bus.core_rdata = load_done ? bus.mem_rdata : fwd ? fwd_data : '0;
    assign bus.core_stall = (bus.core_we & full) | (bus.core_re & ~fwd & ~load_done);
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_be_q   <= ent_be_d;
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized scoreboard bench for store_buffer against a word/byte-level memory model.
module tb_store_buffer;
    localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct {logic [29:0] a; logic [31:0] d; logic [3:0] be;} st_t;
    typedef struct {logic [29:0] a; logic [3:0] be; logic [31:0] d; bit fwd;} ld_t;

    logic clk = 1'b0;
    logic n_rst;
    store_buffer_if sb_if ();
    store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .n_rst(n_rst), .bus(sb_if));
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_pct = 50;
    bit ack_once = 1'b0;
    bit force_ack = 1'b0;
    int reads_seen = 0;
    int ld_cyc = 0;
    st_t sb_q[$];
    ld_t ld_q[$];
    logic [31:0] mem [logic [29:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        if (!mem.exists(w)) mem[w] = $urandom;
        return mem[w];
    endfunction

    // Architectural value of a word: memory overlaid with all buffered stores, oldest first.
    task automatic coherent(input logic [29:0] w, output logic [31:0] v, output logic [3:0] cov, output bit m);
        v = mem_rd(w);
        cov = '0;
        m = 1'b0;
        foreach (sb_q[i]) if (sb_q[i].a == w) begin
            m = 1'b1;
            cov |= sb_q[i].be;
            for (int l = 0; l < 4; l++) if (sb_q[i].be[l]) v[8*l +: 8] = sb_q[i].d[8*l +: 8];
        end
    endtask

    function automatic bit may_read(input logic [29:0] w);
        bit m = 1'b0;
        foreach (sb_q[i]) if (sb_q[i].a == w) m = 1'b1;
        return FWD ? !m : sb_q.size() == 0;
    endfunction

    always @(posedge clk) begin
        #1;
        if (force_ack) sb_if.mem_ack = 1'b1;
        else if (ack_once && sb_if.mem_req) begin
            sb_if.mem_ack = 1'b1;
            ack_once = 1'b0;
        end else sb_if.mem_ack = sb_if.mem_req && ($urandom_range(99) < ack_pct);
        sb_if.mem_rdata = (sb_if.mem_ack && sb_if.mem_req && !sb_if.mem_we) ? mem_rd(sb_if.mem_addr[31:2]) : $urandom;
    end

    always @(negedge clk) begin
        st_t e;
        ld_t l;
        logic [31:0] w;
        if (!n_rst) begin
            reads_seen = 0;
            ld_cyc = 0;
        end else begin
            if (sb_if.core_we) chk("store_stall", sb_if.core_stall, sb_q.size() == DEPTH);
            if (sb_if.mem_req && sb_if.mem_ack && sb_if.mem_we) begin
                chk("wr_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("wr_addr", sb_if.mem_addr, {e.a, 2'b00});
                    chk("wr_data", sb_if.mem_wdata, e.d);
                    chk("wr_be", sb_if.mem_be, e.be);
                    w = mem_rd(e.a);
                    for (int i = 0; i < 4; i++) if (e.be[i]) w[8*i +: 8] = e.d[8*i +: 8];
                    mem[e.a] = w;
                end
            end
            if (sb_if.mem_req && sb_if.mem_ack && !sb_if.mem_we) begin
                chk("rd_expected", ld_q.size() != 0, 1);
                if (ld_q.size() != 0) begin
                    chk("rd_addr", sb_if.mem_addr, {ld_q[0].a, 2'b00});
                    chk("rd_be", sb_if.mem_be, ld_q[0].be);
                    chk("rd_eligible", may_read(ld_q[0].a), 1);
                end
                reads_seen++;
            end
            if (sb_if.core_re && !sb_if.core_stall) begin
                chk("ld_expected", ld_q.size() != 0, 1);
                if (ld_q.size() != 0) begin
                    l = ld_q.pop_front();
                    chk("ld_data", sb_if.core_rdata, l.d);
                    chk("ld_mem_reads", reads_seen, l.fwd ? 0 : 1);
                    chk("ld_stall_free", ld_cyc == 0, l.fwd);
                end
                reads_seen = 0;
                ld_cyc = 0;
            end else begin
                chk("idle_rdata", sb_if.core_rdata, 0);
                if (sb_if.core_re) ld_cyc++;
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, output int stalls);
        st_t e;
        stalls = 0;
        sb_if.core_we = 1'b1;
        sb_if.core_addr = a;
        sb_if.core_wdata = d;
        sb_if.core_be = be;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!sb_if.core_stall) begin
                @(posedge clk);
                #1;
                e.a = a[31:2];
                e.d = d;
                e.be = be;
                sb_q.push_back(e);
                sb_if.core_we = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        tmo("store_accept");
        sb_if.core_we = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] be);
        ld_t l;
        logic [3:0] cov;
        bit m;
        sb_if.core_re = 1'b1;
        sb_if.core_addr = a;
        sb_if.core_be = be;
        l.a = a[31:2];
        l.be = be;
        coherent(l.a, l.d, cov, m);
        l.fwd = FWD && m && ((cov & be) == be);
        if (l.fwd) for (int i = 0; i < 4; i++) if (!be[i]) l.d[8*i +: 8] = 8'h00;
        ld_q.push_back(l);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!sb_if.core_stall) begin
                @(posedge clk);
                #1;
                sb_if.core_re = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tmo("load_complete");
        sb_if.core_re = 1'b0;
        ld_q.delete();
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 500; i++) begin
            if (sb_q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        tmo("drain");
    endtask

    initial begin
        int s;
        logic [31:0] a;
        n_rst = 1'b0;
        sb_if.core_we = 1'b0;
        sb_if.core_re = 1'b0;
        sb_if.core_addr = '0;
        sb_if.core_wdata = '0;
        sb_if.core_be = '0;
        sb_if.mem_ack = 1'b0;
        sb_if.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", sb_if.mem_req, 0);
        chk("rst_mem_we", sb_if.mem_we, 0);
        chk("rst_mem_bus", {sb_if.mem_addr, sb_if.mem_wdata}, 0);
        chk("rst_mem_be", sb_if.mem_be, 0);
        chk("rst_core", {sb_if.core_stall, sb_if.core_rdata}, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        ack_pct = 0;
        for (int k = 0; k < 4; k++) begin
            do_store(32'h100 + 4 * k, $urandom, 4'hf, s);
            chk("fill_no_stall", s, 0);
        end
        @(negedge clk);
        ack_once = 1'b1;
        @(posedge clk);
        #1;
        do_store(32'h110, $urandom, 4'hf, s);
        chk("full_stall_cycles", s, 1);
        ack_pct = 50;
        wait_empty();
        ack_pct = 0;
        do_store(32'h200, 32'hAABBCCDD, 4'hf, s);
        ack_pct = 50;
        do_load(32'h200, 4'hf);
        wait_empty();
        ack_pct = 0;
        do_store(32'h300, 32'h00000011, 4'b0001, s);
        do_store(32'h300, 32'h00002200, 4'b0010, s);
        ack_pct = 50;
        do_load(32'h300, 4'b0011);
        do_load(32'h300, 4'hf);
        wait_empty();
        ack_pct = 0;
        do_store(32'h400, $urandom, 4'hf, s);
        ack_pct = 30;
        do_load(32'h500, 4'hf);
        wait_empty();
        ack_pct = 0;
        for (int k = 0; k < 3; k++) do_store(32'h600 + 4 * k, $urandom, 4'hf, s);
        @(negedge clk);
        chk("pre_rst_wr_req", {sb_if.mem_req, sb_if.mem_we}, 2'b11);
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        sb_q.delete();
        ld_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_mem_req", sb_if.mem_req, 0);
            chk("post_rst_mem_addr", sb_if.mem_addr, 0);
        end
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        ack_pct = 50;
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0) ack_pct = $urandom_range(20, 90);
            a = 32'h1000 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3);
            s = $urandom_range(99);
            if (s < 50) do_store(a, $urandom, 4'($urandom_range(1, 15)), s);
            else if (s < 90) do_load(a, 4'($urandom_range(1, 15)));
            else begin
                @(posedge clk);
                #1;
            end
        end
        ack_pct = 60;
        wait_empty();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
